// File: rtl/control_cmd_pixelreadback_pkg.sv
// Shared sizing helpers and types for the pixel readback control command.
// The write command sizes its address registers with the same functions,
// so both directions always agree on row/column/pixel widths.
package control_cmd_pixelreadback_pkg;

    // Default panel geometry, overridden per product at the top level.
    localparam int DEFAULT_BYTES_PER_PIXEL = 2;
    localparam int DEFAULT_PIXEL_HEIGHT    = 32;
    localparam int DEFAULT_PIXEL_WIDTH     = 64;

    // Which part of the address the capture fragment is currently filling.
    typedef enum logic {
        CAP_ROW    = 1'b0,
        CAP_COLUMN = 1'b1
    } cap_phase_e;

    // Bits needed to address `height` rows (never narrower than one bit).
    function automatic int num_row_address_bits(input int height);
        return (height > 2) ? $clog2(height) : 1;
    endfunction

    // Bits needed to address `width` columns (never narrower than one bit).
    function automatic int num_column_address_bits(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

    // Bits needed to select one byte within a pixel.
    function automatic int num_pixelcolorselect_bits(input int bytes_per_pixel);
        return (bytes_per_pixel > 2) ? $clog2(bytes_per_pixel) : 1;
    endfunction

    // Command-stream bytes that carry the column address (ceil(bits / 8)).
    function automatic int num_column_bytes(input int width);
        return (num_column_address_bits(width) + 7) / 8;
    endfunction

    // Width of a down-counter that holds values 0 .. count-1.
    function automatic int num_counter_bits(input int count);
        return (count > 2) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/control_addr_capture.sv
// Row byte plus little-endian multi-byte column capture from the command
// byte stream. addr_valid is combinational: it is high in the cycle the last
// column byte is being accepted, so a parent FSM can leave its capture state
// on the same edge that stores that byte.
module control_addr_capture
    import control_cmd_pixelreadback_pkg::*;
#(
    parameter int PIXEL_HEIGHT = DEFAULT_PIXEL_HEIGHT,
    parameter int PIXEL_WIDTH  = DEFAULT_PIXEL_WIDTH,
    localparam int ROW_W = num_row_address_bits(PIXEL_HEIGHT),
    localparam int COL_W = num_column_address_bits(PIXEL_WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [7:0]       data_in,
    input  logic             clear,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] column,
    output logic             addr_valid
);

    localparam int NCB   = num_column_bytes(PIXEL_WIDTH);
    localparam int CNT_W = num_counter_bits(NCB);

    cap_phase_e        phase;
    logic [CNT_W-1:0]  byte_cnt;
    logic [CNT_W-1:0]  byte_idx;
    logic [NCB*8-1:0]  col_bytes;
    logic              unused_col_hi;

    // Counter runs NCB-1 down to 0; the first column byte lands in byte 0.
    assign byte_idx   = CNT_W'(NCB - 1) - byte_cnt;
    assign addr_valid = enable && (phase == CAP_COLUMN) && (byte_cnt == '0);

    // Column bits above the address width are received but never used.
    assign column        = col_bytes[COL_W-1:0];
    assign unused_col_hi = ^col_bytes;

    // Capture the row byte, then fill the column register LSB byte first.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            phase     <= CAP_ROW;
            byte_cnt  <= '0;
            row       <= '0;
            col_bytes <= '0;
        end else if (enable) begin
            if (phase == CAP_ROW) begin
                row      <= data_in[ROW_W-1:0];
                byte_cnt <= CNT_W'(NCB - 1);
                phase    <= CAP_COLUMN;
            end else begin
                for (int b = 0; b < NCB; b++) begin
                    if (byte_idx == CNT_W'(b))
                        col_bytes[8*b +: 8] <= data_in;
                end
                if (byte_cnt == '0)
                    phase <= CAP_ROW;
                else
                    byte_cnt <= byte_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/control_cmd_pixelreadback.sv
// Pixel readback control command: parses a row byte and a multi-byte column
// from the command stream, then reads each byte of that pixel from the frame
// buffer (highest byte index first) and streams it out on a valid/ready TX
// byte port. Command bytes arriving while a readback is in flight are dropped.
module control_cmd_pixelreadback
    import control_cmd_pixelreadback_pkg::*;
#(
    parameter int BYTES_PER_PIXEL  = DEFAULT_BYTES_PER_PIXEL,
    parameter int PIXEL_HEIGHT     = DEFAULT_PIXEL_HEIGHT,
    parameter int PIXEL_WIDTH      = DEFAULT_PIXEL_WIDTH,
    parameter int RAM_READ_LATENCY = 1,
    localparam int ROW_W = num_row_address_bits(PIXEL_HEIGHT),
    localparam int COL_W = num_column_address_bits(PIXEL_WIDTH),
    localparam int PIX_W = num_pixelcolorselect_bits(BYTES_PER_PIXEL)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [7:0]       data_in,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] column,
    output logic [PIX_W-1:0] pixel,
    output logic             ram_read_enable,
    input  logic [7:0]       ram_data_in,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             done
);

    localparam int LAT_W = num_counter_bits(RAM_READ_LATENCY);

    typedef enum logic [2:0] {
        ROW_CAPTURE    = 3'd0,
        COLUMN_CAPTURE = 3'd1,
        RAM_ISSUE      = 3'd2,
        RAM_WAIT       = 3'd3,
        TX_SEND        = 3'd4,
        DONE           = 3'd5
    } state_e;

    state_e           state;
    state_e           state_nxt;
    logic [LAT_W-1:0] lat_cnt;
    logic             cap_enable;
    logic             cap_clear;
    logic             addr_valid;
    logic             tx_fire;

    // Only the two capture states listen to the command stream.
    assign cap_enable = enable && ((state == ROW_CAPTURE) || (state == COLUMN_CAPTURE));

    // Address registers are wiped on completion and on any illegal state.
    assign cap_clear = !(state inside {ROW_CAPTURE, COLUMN_CAPTURE, RAM_ISSUE,
                                       RAM_WAIT, TX_SEND});

    assign tx_fire         = tx_valid && tx_ready;
    assign ram_read_enable = (state == RAM_ISSUE);
    assign busy            = (state != ROW_CAPTURE);

    control_addr_capture #(
        .PIXEL_HEIGHT (PIXEL_HEIGHT),
        .PIXEL_WIDTH  (PIXEL_WIDTH)
    ) u_addr_capture (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (cap_enable),
        .data_in    (data_in),
        .clear      (cap_clear),
        .row        (row),
        .column     (column),
        .addr_valid (addr_valid)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= ROW_CAPTURE;
        else
            state <= state_nxt;
    end

    // Next-state logic; an unknown encoding falls back to ROW_CAPTURE.
    always_comb begin
        state_nxt = state;
        case (state)
            ROW_CAPTURE:    if (enable) state_nxt = COLUMN_CAPTURE;
            COLUMN_CAPTURE: if (addr_valid) state_nxt = RAM_ISSUE;
            RAM_ISSUE:      state_nxt = RAM_WAIT;
            RAM_WAIT:       if (lat_cnt == '0) state_nxt = TX_SEND;
            TX_SEND:        if (tx_fire) state_nxt = (pixel == '0) ? DONE : RAM_ISSUE;
            DONE:           state_nxt = ROW_CAPTURE;
            default:        state_nxt = ROW_CAPTURE;
        endcase
    end

    // Datapath: pixel byte select, read latency wait, TX byte and done pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lat_cnt  <= '0;
            pixel    <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                ROW_CAPTURE: ;
                COLUMN_CAPTURE: begin
                    if (addr_valid)
                        pixel <= PIX_W'(BYTES_PER_PIXEL - 1);
                end
                RAM_ISSUE: begin
                    lat_cnt <= LAT_W'(RAM_READ_LATENCY - 1);
                end
                RAM_WAIT: begin
                    if (lat_cnt == '0) begin
                        tx_data  <= ram_data_in;
                        tx_valid <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                TX_SEND: begin
                    // tx_data/tx_valid simply hold until the consumer takes the byte.
                    if (tx_fire) begin
                        tx_valid <= 1'b0;
                        if (pixel == '0)
                            done <= 1'b1;
                        else
                            pixel <= pixel - 1'b1;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    pixel   <= '0;
                    tx_data <= '0;
                end
                default: begin
                    lat_cnt  <= '0;
                    pixel    <= '0;
                    tx_data  <= '0;
                    tx_valid <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_cmd_pixelreadback.sv
// Randomized scoreboard bench for the pixel readback command. The stimulus
// side pushes, per command, the expected RAM reads and TX bytes; a negedge
// monitor pops and compares whenever the DUT strobes the RAM, hands off a TX
// byte or pulses done.
module tb_control_cmd_pixelreadback;

    localparam int BPP    = 3;
    localparam int HEIGHT = 32;
    localparam int WIDTH  = 512;
    localparam int LAT    = 3;
    localparam int RW     = $clog2(HEIGHT);
    localparam int CW     = $clog2(WIDTH);
    localparam int PW     = $clog2(BPP);
    localparam int NCB    = (CW + 7) / 8;
    localparam int CVW    = 8 * NCB;

    typedef struct { logic [RW-1:0] r; logic [CW-1:0] c; logic [PW-1:0] p; } rd_exp_t;
    typedef struct { logic [7:0] data; bit last; } tx_exp_t;
    typedef struct { bit v; logic [7:0] d; } ram_slot_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic [7:0]    data_in = 8'h00;
    logic [RW-1:0] row;
    logic [CW-1:0] column;
    logic [PW-1:0] pixel;
    logic          ram_read_enable;
    logic [7:0]    ram_data_in = 8'h00;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic          busy;
    logic          done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_strobe_cyc = -1;
    int exp_valid_cyc = -1;
    int done_due = -1;
    int ready_mode = 0;
    int hold = 0;

    rd_exp_t   rd_q[$];
    tx_exp_t   tx_q[$];
    ram_slot_t ram_pipe[LAT+1];

    control_cmd_pixelreadback #(
        .BYTES_PER_PIXEL  (BPP),
        .PIXEL_HEIGHT     (HEIGHT),
        .PIXEL_WIDTH      (WIDTH),
        .RAM_READ_LATENCY (LAT)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .enable          (enable),
        .data_in         (data_in),
        .row             (row),
        .column          (column),
        .pixel           (pixel),
        .ram_read_enable (ram_read_enable),
        .ram_data_in     (ram_data_in),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Frame buffer contents: a fixed scramble of the address.
    function automatic logic [7:0] mem_val(input int r, input int c, input int p);
        int v;
        v = (r * 29) ^ (c * 7) ^ (p * 85) ^ 60;
        return v[7:0];
    endfunction

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_all_zero(input string name);
        logic [RW+CW+PW+12-1:0] all;
        all = {row, column, pixel, ram_read_enable, tx_data, tx_valid, busy, done};
        check(all == '0, name, longint'(all), 0);
    endtask

    // RAM with LAT cycles of read latency; junk on the bus otherwise.
    always @(negedge clk) begin
        for (int k = LAT; k > 0; k--) ram_pipe[k] = ram_pipe[k-1];
        ram_pipe[0].v = ram_read_enable;
        ram_pipe[0].d = mem_val(int'(row), int'(column), int'(pixel));
        ram_data_in = ram_pipe[LAT].v ? ram_pipe[LAT].d : 8'($urandom);
    end

    // Consumer: 0 always ready, 1 random, 2 stall 4 cycles per byte, 3 never.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: tx_ready = 1'b1;
            1: tx_ready = ($urandom_range(0, 2) != 0);
            2: begin
                if (tx_valid && hold < 4) begin
                    tx_ready = 1'b0;
                    hold++;
                end else begin
                    tx_ready = 1'b1;
                    if (!tx_valid) hold = 0;
                end
            end
            default: tx_ready = 1'b0;
        endcase
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin : mon
        rd_exp_t re;
        tx_exp_t te;
        bit prev_valid, prev_hs;
        logic [7:0] prev_data;
        if (!reset_n) begin
            prev_valid = 1'b0;
            prev_hs = 1'b0;
            done_due = -1;
        end else begin
            if (prev_valid && !prev_hs)
                check(tx_valid && tx_data == prev_data, "tx_hold_stable",
                      longint'({tx_valid, tx_data}), longint'({1'b1, prev_data}));
            if (tx_valid && !prev_valid)
                check(cyc == exp_valid_cyc, "tx_valid_latency", cyc, exp_valid_cyc);
            if (ram_read_enable) begin
                if (rd_q.size() == 0) begin
                    check(1'b0, "strobe_unexpected", longint'({row, column, pixel}), 0);
                end else begin
                    re = rd_q.pop_front();
                    check({row, column, pixel} == {re.r, re.c, re.p}, "strobe_addr",
                          longint'({row, column, pixel}), longint'({re.r, re.c, re.p}));
                    check(cyc == exp_strobe_cyc, "strobe_latency", cyc, exp_strobe_cyc);
                end
            end
            if (tx_valid && tx_ready) begin
                if (tx_q.size() == 0) begin
                    check(1'b0, "tx_unexpected", longint'(tx_data), 0);
                end else begin
                    te = tx_q.pop_front();
                    check(tx_data == te.data, "tx_data", longint'(tx_data), longint'(te.data));
                    if (te.last) begin
                        done_due = cyc + 1;
                    end else begin
                        exp_strobe_cyc = cyc + 1;
                        exp_valid_cyc = cyc + 2 + LAT;
                    end
                end
            end
            if (done || cyc == done_due)
                check(done && cyc == done_due, "done_pulse", longint'(done), 1);
            prev_valid = tx_valid;
            prev_data = tx_data;
            prev_hs = tx_valid && tx_ready;
        end
    end

    // Issue one command; wait for idle (or for the first TX byte when stop_at_tx).
    task automatic send_cmd(input logic [7:0] rb, input logic [CVW-1:0] cv,
                            input bit junk, input bit gaps, input bit stop_at_tx,
                            input string tag);
        logic [7:0] bytes [NCB+1];
        logic [RW-1:0] r;
        logic [CW-1:0] c;
        int n;
        bit finished;
        bytes[0] = rb;
        for (int b = 0; b < NCB; b++) bytes[b+1] = 8'(cv >> (8 * b));
        for (int i = 0; i <= NCB; i++) begin
            if (gaps) begin
                n = $urandom_range(0, 2);
                for (int g = 0; g < n; g++) begin
                    @(posedge clk); #1;
                    enable = 1'b0;
                    data_in = 8'($urandom);
                end
            end
            @(posedge clk); #1;
            enable = 1'b1;
            data_in = bytes[i];
        end
        r = rb[RW-1:0];
        c = cv[CW-1:0];
        for (int p = BPP - 1; p >= 0; p--) begin
            rd_q.push_back('{r: r, c: c, p: PW'(p)});
            tx_q.push_back('{data: mem_val(int'(r), int'(c), p), last: (p == 0)});
        end
        exp_strobe_cyc = cyc + 1;
        exp_valid_cyc = cyc + 2 + LAT;
        finished = 1'b0;
        for (int k = 0; k < 400 && !finished; k++) begin
            @(posedge clk); #1;
            enable = 1'b0;
            if (stop_at_tx ? tx_valid : !busy) begin
                finished = 1'b1;
            end else if (junk) begin
                enable = 1'($urandom);
                data_in = 8'($urandom);
            end
        end
        check(finished, {tag, "_complete"}, longint'(finished), 1);
        if (!stop_at_tx) begin
            check(rd_q.size() == 0 && tx_q.size() == 0, {tag, "_drained"},
                  rd_q.size() + tx_q.size(), 0);
            check_all_zero({tag, "_idle_cleared"});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        logic [7:0] rb;
        logic [CVW-1:0] cv;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        reset_n = 1'b1;

        // Directed address patterns.
        ready_mode = 0;
        send_cmd(8'h05, CVW'(16'h0012), 1'b0, 1'b0, 1'b0, "basic");
        send_cmd(8'h03, CVW'(16'h0134), 1'b0, 1'b0, 1'b0, "multibyte_col");
        send_cmd(8'hFF, CVW'(16'hFFFF), 1'b0, 1'b0, 1'b0, "addr_truncate");

        // Backpressure: each byte stalls for 4 cycles.
        ready_mode = 2;
        send_cmd(8'h11, CVW'(16'h01A5), 1'b0, 1'b0, 1'b0, "backpressure");

        // Junk command bytes while the readback is running.
        ready_mode = 1;
        send_cmd(8'h0A, CVW'(16'h00C3), 1'b1, 1'b0, 1'b0, "junk_ignored");
        send_cmd(8'h07, CVW'(16'h0100), 1'b0, 1'b0, 1'b0, "after_junk");

        // Reset while the first byte is waiting in TX_SEND.
        ready_mode = 3;
        send_cmd(8'h09, CVW'(16'h0042), 1'b0, 1'b0, 1'b1, "pre_reset");
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        rd_q.delete();
        tx_q.delete();
        check_all_zero("reset_mid_tx");
        ready_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        check(!done && !busy, "reset_no_done", longint'({done, busy}), 0);
        send_cmd(8'h1C, CVW'(16'h01F0), 1'b0, 1'b0, 1'b0, "after_reset");

        // Randomized commands, consumer behaviour, gaps and junk.
        for (int i = 0; i < 25; i++) begin
            ready_mode = $urandom_range(0, 2);
            rb = 8'($urandom);
            cv = CVW'($urandom);
            send_cmd(rb, cv, 1'($urandom), 1'($urandom), 1'b0, "random");
        end

        repeat (5) @(posedge clk);
        #1;
        check(rd_q.size() == 0 && tx_q.size() == 0, "final_drained",
              rd_q.size() + tx_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
